// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative multiply/divide unit.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package muldiv_pkg;

    // RV32M/RV64M funct3 encodings
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // True for the whole divider family (quotient and remainder ops).
    function automatic logic is_div(input op_t op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    // True when the divider result is the remainder rather than the quotient.
    function automatic logic is_rem(input op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // rs1 is interpreted as two's complement.
    function automatic logic a_signed(input op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is interpreted as two's complement.
    function automatic logic b_signed(input op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Sign handling: operand magnitudes on accept, result negation/select on fix.
// Latency: purely combinational.
// Backpressure: none; the parent sequences when each half is used.
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    // accept-side magnitude extraction
    input  op_t             op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] a_mag,
    output logic [XLEN-1:0] b_mag,
    output logic            a_neg,
    output logic            b_neg,
    // fix-side result correction
    input  op_t             fix_op,
    input  logic            fix_a_neg,
    input  logic            fix_b_neg,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] result
);

    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;

    // Magnitudes: negating MIN_SIGNED wraps back to 2^(XLEN-1), which is the
    // correct unsigned magnitude, so no special case is needed.
    always_comb begin
        a_neg = a_signed(op) & a[XLEN-1];
        b_neg = b_signed(op) & b[XLEN-1];
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;
    end

    // Apply recorded signs and pick the architectural result.
    always_comb begin
        prod     = {hi, lo};
        prod_fix = (fix_a_neg ^ fix_b_neg) ? (~prod + 1'b1) : prod;
        quot_fix = (fix_a_neg ^ fix_b_neg) ? (~lo + 1'b1) : lo;
        rem_fix  = fix_a_neg ? (~hi + 1'b1) : hi;
        if (is_div(fix_op)) begin
            result = is_rem(fix_op) ? rem_fix : quot_fix;
        end else if (fix_op == OP_MUL) begin
            result = prod_fix[XLEN-1:0];
        end else begin
            result = prod_fix[2*XLEN-1:XLEN];
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV M-extension unit: shift-add multiply, restoring divide, one bit per cycle.
// Latency: XLEN+1 cycles accept-to-valid; div-by-zero/overflow fast path is 1 cycle.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [TAGW-1:0] out_tag
);

    localparam int              CW    = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   LAST  = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_S = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state;
    state_t          state_nxt;
    op_t             acc_op;
    op_t             op_q;
    logic [TAGW-1:0] tag_q;
    logic            sa_q;
    logic            sb_q;
    logic            fast_q;
    logic [CW-1:0]   cnt;
    // acc: product high half / partial remainder
    // lo : multiplier shifting out, product low half / dividend shifting out, quotient in
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] bmag;

    logic            accept;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] fix_result;
    logic            b_zero;
    logic            ovf;
    logic            fast;
    logic [XLEN-1:0] fast_val;
    logic [XLEN-1:0] acc_nxt;
    logic [XLEN-1:0] lo_nxt;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;

    assign acc_op   = op_t'(in_op);
    assign in_ready = (state == IDLE);
    assign accept   = in_valid & in_ready & ~flush;

    muldiv_signfix #(.XLEN(XLEN)) u_signfix (
        .op        (acc_op),
        .a         (in_a),
        .b         (in_b),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .a_neg     (a_neg),
        .b_neg     (b_neg),
        .fix_op    (op_q),
        .fix_a_neg (sa_q),
        .fix_b_neg (sb_q),
        .hi        (acc),
        .lo        (lo),
        .result    (fix_result)
    );

    // Detect the cases the iterative datapath would get wrong and their fixed answers.
    always_comb begin
        b_zero   = (in_b == '0);
        ovf      = ((acc_op == OP_DIV) || (acc_op == OP_REM)) && (in_a == MIN_S) && (in_b == '1);
        fast     = is_div(acc_op) && (b_zero || ovf);
        fast_val = '0;
        if (b_zero) begin
            fast_val = is_rem(acc_op) ? in_a : '1;
        end else if (ovf) begin
            fast_val = is_rem(acc_op) ? '0 : MIN_S;
        end
    end

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, bmag} : '0);
        div_shift = {acc, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, bmag};
        if (is_div(op_q)) begin
            // remainder stays below divisor, so the kept value fits XLEN bits
            acc_nxt = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            lo_nxt  = {lo[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            acc_nxt = mul_sum[XLEN:1];
            lo_nxt  = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = fast ? FIX : CALC;
            CALC: if (cnt == LAST) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Operand latch, iteration registers and result/output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q       <= OP_MUL;
            tag_q      <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            fast_q     <= 1'b0;
            cnt        <= '0;
            acc        <= '0;
            lo         <= '0;
            bmag       <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= acc_op;
                        tag_q  <= in_tag;
                        sa_q   <= a_neg;
                        sb_q   <= b_neg;
                        fast_q <= fast;
                        cnt    <= '0;
                        acc    <= '0;
                        lo     <= fast ? fast_val : a_mag;
                        bmag   <= b_mag;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    out_result <= fast_q ? lo : fix_result;
                    out_tag    <= tag_q;
                    out_valid  <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter (XLEN=32) with an expected-result scoreboard.
// Latency: checks exact accept-to-valid cycle counts.
// Backpressure: exercises held results, flush and reset aborts.
module tb_muldiv_iter;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    muldiv_iter #(.XLEN(32), .TAGW(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < DIV) return 1'b0;
        if (b == 32'd0) return 1'b1;
        return ((op == DIV) || (op == REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    endfunction

    // Reference behaviour from RISC-V M semantics using wide arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sbv, ua, ub, p;
        logic signed [31:0] a32, b32;
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        a32 = a;
        b32 = b;
        case (op)
            MUL:    begin p = ua * ub;  return p[31:0];  end
            MULH:   begin p = sa * sbv; return p[63:32]; end
            MULHSU: begin p = sa * ub;  return p[63:32]; end
            MULHU:  begin p = ua * ub;  return p[63:32]; end
            DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return a32 / b32;
            end
            DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM:    begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return a32 % b32;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Drive one request; it is accepted on the next rising edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tg);
        exp_t e;
        chk("issue_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tg;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.res = model(op, a, b);
        e.tag = tg;
        e.lat = is_fast(op, a, b) ? 1 : 33;
        sb.push_back(e);
    endtask

    // Wait for a result, check it against the scoreboard, optionally stall, then accept.
    task automatic collect(input int hold);
        int   n;
        bit   rdy_seen;
        exp_t e;
        n = 0;
        rdy_seen = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (in_ready) rdy_seen = 1;
        end
        if (!out_valid || sb.size() == 0) begin
            chk("result_timeout", out_valid, 1);
            if (sb.size() != 0) void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        chk("latency", n, e.lat);
        chk("result", out_result, e.res);
        chk("tag", out_tag, e.tag);
        chk("in_ready_busy", rdy_seen, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_result", out_result, e.res);
            chk("hold_tag", out_tag, e.tag);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("drop_valid", out_valid, 0);
        chk("idle_in_ready", in_ready, 1);
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tg);
        issue(op, a, b, tg);
        collect(0);
    endtask

    // Watch for a spurious result after an abort.
    task automatic quiet(input int cycles);
        bit seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        chk("abort_no_valid", seen, 0);
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_op     = MUL;
        in_a      = 32'd3;
        in_b      = 32'd3;
        in_tag    = 5'd1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_tag", out_tag, 0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_no_valid", out_valid, 0);

        // multiply variants
        run(MUL,    32'd7,          32'hFFFF_FFFD, 5'd5);
        run(MULH,   32'h8000_0000,  32'h8000_0000, 5'd6);
        run(MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7);
        run(MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8);
        // divide variants
        run(DIV,    32'hFFFF_FFF9,  32'd2,         5'd9);
        run(REM,    32'hFFFF_FFF9,  32'd2,         5'd10);
        run(DIVU,   32'd100,        32'd7,         5'd11);
        run(REMU,   32'd100,        32'd7,         5'd12);
        // fast path
        run(DIVU,   32'd123,        32'd0,         5'd13);
        run(REM,    32'd123,        32'd0,         5'd14);
        run(DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd15);
        run(REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd16);

        // backpressure, then immediate follow-on request
        issue(DIV, 32'd1000, 32'hFFFF_FFFD, 5'd17);
        collect(5);
        run(REMU, 32'd1000, 32'd33, 5'd18);

        // random mix across all ops
        for (int i = 0; i < 10; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            run(3'(i % 8), ra, rb, 5'(i + 20));
        end

        // flush at CALC iteration 10
        issue(DIVU, 32'hDEAD_BEEF, 32'd3, 5'd2);
        repeat (9) @(posedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_in_ready", in_ready, 1);
        chk("flush_out_valid", out_valid, 0);
        void'(sb.pop_back());
        quiet(40);
        run(DIVU, 32'd9, 32'd3, 5'd3);

        // reset pulsed mid-CALC
        issue(MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd4);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_result", out_result, 0);
        chk("arst_out_tag", out_tag, 0);
        @(negedge clk);
        reset = 1'b0;
        void'(sb.pop_back());
        quiet(40);
        run(DIVU, 32'd9, 32'd3, 5'd3);

        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
Iterative RV32M/RV64M multiply/divide unit. It extends the single-cycle ALU with all eight M-extension ops at parametrised width. It sits beside the ALU and is driven by the controller through a valid/ready handshake. It computes one result bit per cycle: shift-add for multiply, restoring division for divide. Division by zero and signed overflow are handled by a one-cycle fast path.

Parameters:
XLEN, 32, operand/result width in bits (32 or 64).
TAGW, 5, width of the opaque tag (destination register) carried with each op.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high.
flush  input  1  synchronous abort of any op in flight.
in_valid  input  1  request present.
in_ready  output  1  unit can accept a request; high only in IDLE.
in_op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
in_a  input  XLEN  rs1 value.
in_b  input  XLEN  rs2 value.
in_tag  input  TAGW  tag, returned unchanged.
out_valid  output  1  result present; held until accepted.
out_ready  input  1  consumer accepts result.
out_result  output  XLEN  result.
out_tag  output  TAGW  tag of the request that produced the result.

Behaviour:
- Reset (async): state IDLE; out_valid=0; out_result=0; out_tag=0; counter=0. in_ready=1 while in IDLE, including during reset. Requests are ignored while reset is high.
- States: IDLE, CALC, FIX, DONE.
- Accept: in_valid & in_ready at edge E.
  - Latch op, tag and operand magnitudes.
  - Record result sign:
    - MULH/DIV/REM: signed A and B.
    - MULHSU: A signed, B unsigned.
    - Others: unsigned.
  - State goes to CALC with counter=0.
- Fast path, checked at accept, next state DONE at edge E+1, no CALC:
  - DIV/DIVU with b=0: result all-ones.
  - REM/REMU with b=0: result a.
  - DIV with a=MIN_SIGNED, b=-1: result MIN_SIGNED.
  - REM with a=MIN_SIGNED, b=-1: result 0.
- CALC: one iteration per edge; counter increments.
  - Multiply: 2*XLEN-bit product register.
  - Divide: XLEN-bit remainder and quotient.
  - After the XLEN-th iteration (edge E+XLEN), state goes to FIX.
- FIX: one edge.
  - Conditionally negate the magnitude result per the recorded sign.
  - Quotient is negative iff signs differ.
  - Remainder takes the dividend's sign.
  - Select low half (MUL) or high half (MULH*), or quotient/remainder.
  - Register out_result/out_tag; state goes to DONE.
  - out_valid is first high after edge E+XLEN+1.
- DONE: out_valid=1; out_result/out_tag stable while out_ready=0.
  - out_valid & out_ready at an edge: state goes to IDLE and out_valid drops at that edge.
  - in_ready is 0 in DONE, so no same-edge re-accept; the next accept is possible one edge later.
- flush=1 at an edge: from any state, go to IDLE and clear out_valid. A pending DONE result is discarded.
  - flush takes priority over accept and over out_ready.
  - With in_valid & in_ready & flush at the same edge, the request is dropped.
- reset mid-op: immediate IDLE, no result produced.
- Widths:
  - Magnitude of MIN_SIGNED is 2^(XLEN-1), held unsigned in XLEN bits.
  - Final negation is two's complement modulo 2^XLEN (or 2^(2XLEN) for the product).
  - MUL low half is sign-agnostic.
- The counter is clog2(XLEN)+1 bits wide; no wrap occurs within an op.

Decomposition:
- Package muldiv_pkg:
  - typedef enum op_t for the eight funct3 codes.
  - typedef enum state_t {IDLE, CALC, FIX, DONE}.
  - Helper functions is_div(op), is_rem(op), a_signed(op), b_signed(op).
- One sub-module: muldiv_signfix, purely combinational.
  - Magnitude extraction on accept.
  - Conditional negation and half/quotient/remainder select in FIX.
- The FSM and iteration registers stay in muldiv_iter.

Test Plan:
1. MUL a=7, b=0xFFFFFFFD (XLEN=32), tag=5 -> out_result=0xFFFFFFEB, out_tag=5, out_valid first high exactly 33 edges after the accept edge; in_ready=0 throughout.
2. MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
4. Fast path:
   - DIVU 123/0 -> 0xFFFFFFFF.
   - REM 123/0 -> 123.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
   - REM 0x80000000/0xFFFFFFFF -> 0.
   - Each: out_valid high after edge E+1.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_result/out_tag constant and in_ready=0. Raise out_ready -> IDLE next edge; a new request accepted one edge later completes correctly.
6. Abort:
   - flush at CALC iteration 10 -> IDLE next edge, out_valid never asserts; a following DIVU 9/3 yields 3.
   - Repeat with reset pulsed mid-CALC -> same outcome, all outputs at reset values.
